// File: rtl/addsub_share_arb_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter: opcodes, FSM encoding and
// the default datapath width.
package addsub_share_arb_pkg;

  localparam int unsigned W_DEFAULT = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Every opcode except ADD runs the unit as a subtractor.
  function automatic logic op_mode(logic [1:0] op);
    return op != OP_ADD;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational shared add/subtract unit: s = a + (b ^ {W{m}}) + m, ripple carry.
module addsub_core #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] bx;
  logic [W:0]   c;

  assign bx   = b ^ {W{m}};
  assign c[0] = m;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/addsub_share_arb.sv
// Round-robin arbiter that sequences two requesters onto one shared add/subtract unit
// and returns the result plus unsigned compare flags tagged to the winner.
module addsub_share_arb
  import addsub_share_arb_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_eq,
  output logic         rsp_gt,
  output logic         rsp_lt,
  output logic         busy
);

  state_e state_q, state_d;

  logic         last_grant_q;
  logic         id_q;
  logic [W-1:0] a_q, b_q;
  logic [1:0]   op_q;

  logic any_valid, winner, accept;

  logic [W-1:0] sum;
  logic         cout;

  logic [W-1:0] result_d, result_q;
  logic         carry_q;
  logic         eq_d, gt_d, lt_d;
  logic         eq_q, gt_q, lt_q;

  // Arbitration: a sole requester wins outright; on contention the one not granted last.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    winner    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept    = (state_q == StIdle) && any_valid;
  end

  assign req0_ready = accept & ~winner;
  assign req1_ready = accept & winner;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
    end else if (accept) begin
      last_grant_q <= winner;
      id_q         <= winner;
      a_q          <= winner ? req1_a  : req0_a;
      b_q          <= winner ? req1_b  : req0_b;
      op_q         <= winner ? req1_op : req0_op;
    end
  end

  addsub_core #(
    .W(W)
  ) u_core (
    .a    (a_q),
    .b    (b_q),
    .m    (op_mode(op_q)),
    .s    (sum),
    .cout (cout)
  );

  // In subtract mode cout is the "no borrow" bit, i.e. a >= b.
  always_comb begin
    result_d = sum;
    eq_d     = 1'b0;
    gt_d     = 1'b0;
    lt_d     = 1'b0;
    if (op_q == OP_MAX) begin
      result_d = cout ? a_q : b_q;
    end
    if (op_q != OP_ADD) begin
      eq_d = ~|sum;
      gt_d = cout & ~eq_d;
      lt_d = ~cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else if (state_q == StExec) begin
      result_q <= result_d;
      carry_q  <= cout;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign rsp0_valid = (state_q == StResp) & ~id_q;
  assign rsp1_valid = (state_q == StResp) & id_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_eq     = eq_q;
  assign rsp_gt     = gt_q;
  assign rsp_lt     = lt_q;
  assign busy       = state_q != StIdle;

endmodule

// File: tb/tb_addsub_share_arb.sv
// Self-checking bench for addsub_share_arb: directed cases plus randomized traffic
// against an arithmetic reference model.
module tb_addsub_share_arb;

  localparam int unsigned W = 4;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] CMP = 2'b10;
  localparam logic [1:0] MAX = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_result;
  logic         rsp_carry, rsp_eq, rsp_gt, rsp_lt, busy;

  always #5 clk = ~clk;

  addsub_share_arb #(
    .W(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_eq     (rsp_eq),
    .rsp_gt     (rsp_gt),
    .rsp_lt     (rsp_lt),
    .busy       (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        model_last;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         eq;
    logic         gt;
    logic         lt;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    exp_t        r;
    int unsigned ai, bi, md, tot;
    ai  = a;
    bi  = b;
    md  = 1 << W;
    r   = '0;
    if (op == ADD) begin
      tot   = ai + bi;
      r.res = W'(tot % md);
      r.c   = tot >= md;
    end else begin
      r.res = W'((ai + md - bi) % md);
      r.c   = ai >= bi;
      r.eq  = ai == bi;
      r.gt  = ai > bi;
      r.lt  = ai < bi;
      if (op == MAX) r.res = (ai >= bi) ? a : b;
    end
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rsp0"}, 32'(rsp0_valid), 0);
    check({tag, "_rsp1"}, 32'(rsp1_valid), 0);
    check({tag, "_result"}, 32'(rsp_result), 0);
    check({tag, "_flags"}, {28'd0, rsp_carry, rsp_eq, rsp_gt, rsp_lt}, 0);
  endtask

  // One full transaction: accept cycle, EXEC, RESP, then one hold cycle back in IDLE.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [1:0] op0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] op1);
    logic exp_win;
    exp_t e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    #1;
    exp_win = (v0 && v1) ? ~model_last : v1;
    e = exp_win ? ref_model(a1, b1, op1) : ref_model(a0, b0, op0);
    check("ready0_idle", 32'(req0_ready), 32'(!exp_win));
    check("ready1_idle", 32'(req1_ready), 32'(exp_win));
    check("busy_idle", 32'(busy), 0);
    @(posedge clk); #1;
    model_last = exp_win;
    check("busy_exec", 32'(busy), 1);
    check("ready_exec", {30'd0, req0_ready, req1_ready}, 0);
    check("rsp_exec", {30'd0, rsp0_valid, rsp1_valid}, 0);
    // Operands are don't-care once accepted; scramble them to prove they were latched.
    req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 2'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 2'($urandom);
    @(posedge clk); #1;
    check("rsp0_valid", 32'(rsp0_valid), 32'(!exp_win));
    check("rsp1_valid", 32'(rsp1_valid), 32'(exp_win));
    check("ready_resp", {30'd0, req0_ready, req1_ready}, 0);
    check("result", 32'(rsp_result), 32'(e.res));
    check("carry", 32'(rsp_carry), 32'(e.c));
    check("flags", {29'd0, rsp_eq, rsp_gt, rsp_lt}, {29'd0, e.eq, e.gt, e.lt});
    @(posedge clk); #1;
    check("rsp_end", {30'd0, rsp0_valid, rsp1_valid}, 0);
    check("result_hold", 32'(rsp_result), 32'(e.res));
    check("flags_hold", {28'd0, rsp_carry, rsp_eq, rsp_gt, rsp_lt},
          {28'd0, e.c, e.eq, e.gt, e.lt});
  endtask

  task automatic idle_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("ready_none", {30'd0, req0_ready, req1_ready}, 0);
    check("busy_none", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = ADD;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = ADD;
    model_last = 1'b1;
    #3;
    check_idle_outputs("reset");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1, 0, 9, 3, SUB, 0, 0, ADD);
    run_op(0, 1, 0, 0, ADD, 3, 9, CMP);
    for (int i = 0; i < 4; i++) begin
      run_op(1, 1, 15, 1, ADD, 7, 7, ADD);
    end
    run_op(1, 0, 5, 5, MAX, 0, 0, ADD);
    run_op(0, 1, 0, 0, ADD, 2, 12, MAX);
    idle_cycle();

    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        idle_cycle();
      end else begin
        run_op(sel[0] | ~sel[1], sel[1] | sel[2],
               W'($urandom), W'($urandom), 2'($urandom),
               W'($urandom), W'($urandom), 2'($urandom));
      end
    end

    // Reset in the middle of an operation: no response, outputs clear at once.
    run_op(1, 0, 15, 15, ADD, 0, 0, ADD);
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd3; req0_op = SUB;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    check("midop_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midop_reset");
    req1_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("midop_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 0);
    end
    rst_n = 1'b1;
    model_last = 1'b1;
    run_op(1, 1, 4, 6, SUB, 8, 8, CMP);
    run_op(1, 1, 3, 3, ADD, 1, 2, MAX);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/addsub_share_arb.md
Name: addsub_share_arb

Overview:
- Two-requester arbiter and sequencer for a single shared W-bit add/subtract datapath.
- Each requester submits operands and an opcode with a valid/ready handshake. The block grants round-robin, latches the operands and runs the shared unit for one cycle.
- Returns the result and the magnitude-compare flags (eq/gt/lt) tagged to the winner.
- Sits between two client blocks (for example a keypad/switch front end and a test sequencer) and the display/compare path.

Parameters:
- W, 4, operand/result width in bits (min 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req0_op  in  2  requester 0 opcode: 00 ADD, 01 SUB, 10 CMP, 11 MAX.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- rsp0_valid  out  1  one-cycle pulse: response belongs to requester 0.
- rsp1_valid  out  1  one-cycle pulse: response belongs to requester 1.
- rsp_result  out  W  result; valid while either rsp*_valid is high.
- rsp_carry  out  1  carry-out of the shared unit.
- rsp_eq, rsp_gt, rsp_lt  out  1 each  unsigned A vs B flags.
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, select the winner and go to EXEC.
  - Winner rule: the sole valid requester; if both are valid, the requester != last_grant.
  - reqN_ready (winner only) is combinational and high only in IDLE during this cycle.
  - Latch a, b, op and the winner id on this edge; update last_grant to the winner.
- EXEC:
  - Shared unit computes from latched operands. Mode M = 0 for ADD, 1 for SUB/CMP/MAX; the unit computes A + (B xor {W{M}}) + M.
  - Result and flags registered at the end of the cycle. Go to RESP.
- RESP:
  - rsp<id>_valid = 1 for exactly one cycle. Go to IDLE.
  - No response backpressure: the client must sample in this cycle.
- Latency: accept edge at cycle N, rsp_valid high during cycle N+2. Peak throughput is one operation per 3 cycles; the next accept can occur in the cycle after RESP.
- Results:
  - ADD: result = (A+B) mod 2^W; carry = overflow bit; eq/gt/lt = 0.
  - SUB: result = (A-B) mod 2^W; carry = 1 iff A >= B (unsigned).
  - CMP: result = (A-B) mod 2^W, as SUB; flags are the deliverable.
  - MAX: result = carry ? A : B; carry as SUB.
  - Flags for SUB/CMP/MAX: eq = (difference == 0); gt = carry & ~eq; lt = ~carry. Exactly one of the three is high.
- rsp_result and flags hold their values after RESP until the next EXEC completes.
- Requester inputs are don't-care while its ready is low. A requester holding valid across RESP is re-arbitrated in the next IDLE.
- Fairness: with both valid continuously, grants strictly alternate 0,1,0,1.
- Reset mid-operation: async clear to the reset state; the in-flight operation is dropped with no rsp pulse. First grant after reset goes to requester 0.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD/OP_SUB/OP_CMP/OP_MAX;
  - FSM state encoding (IDLE=0, EXEC=1, RESP=2);
  - default W.
- One sub-module, addsub_core: parameter W; inputs a, b, m; outputs s[W-1:0], cout. It is purely combinational (xor-conditioned ripple adder), and this block registers its outputs.

Test Plan:
- Reset then req0 only: A=9, B=3, op=SUB -> req0_ready at cycle 0; rsp0_valid at cycle 2; result=6, carry=1, gt=1, eq=0, lt=0.
- req1 only: A=3, B=9, op=CMP -> rsp1_valid; result=0xA; carry=0; lt=1.
- Both valid continuously with op=ADD (A=15, B=1 on req0; A=7, B=7 on req1) -> grants alternate 0,1,0,1.
  - req0 responses: result=0, carry=1.
  - req1 responses: result=14, carry=0.
  - No two consecutive grants to the same requester.
- MAX and equality: A=5, B=5 -> result=5, eq=1. A=2, B=12 -> result=12, lt=1.
- Reset mid-op: assert rst_n=0 during EXEC -> no rsp pulse; outputs 0 immediately. After release with both valid, first grant goes to req0.
